mem_burst_reader: RTL and testbench

- Read-side companion to the memory storage chain (bit/register/RAM): streams a burst of consecutive words out of a synchronous RAM.
- Accepts a base address and length, issues one RAM read per word and absorbs the RAM's 1-cycle read latency.
- Presents words in address order on a valid/ready output stream with full backpressure.
- Sits between the RAM array and any consumer (CPU load path, debug dump, display scanner).

---
 rtl/mem_burst_reader.sv | 161 ++++++++++++++++
 tb/tb_mem_burst_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Streams a burst of consecutive RAM words onto a valid/ready output, hiding the RAM's 1-cycle read latency.
// Latency: first word visible two edges after start; 1 word/cycle sustained; stalls hold data with <=2 words buffered.
module mem_burst_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LEN_ZERO = '0;
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rd_left_q, rd_left_d;
  logic [ADDR_W:0]     xf_left_q, xf_left_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_q [2];
  logic [DATA_W-1:0]   fifo_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   last_q, last_d;

  logic                pop;
  logic                rd_en;
  logic [2:0]          occupancy;
  logic [DATA_W-1:0]   head;

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};

  // A same-cycle pop frees a slot, which keeps the stream bubble-free at full rate.
  assign rd_en = (state_q == S_READ) && (rd_left_q != LEN_ZERO) &&
                 ((occupancy < 3'd2) || pop);

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_data  = out_valid ? head : last_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_left_d = rd_left_q;
    xf_left_d = xf_left_q;

    if (pop) begin
      xf_left_d = xf_left_q - LEN_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != LEN_ZERO) begin
            state_d   = S_READ;
            addr_d    = base_addr;
            rd_left_d = length;
            xf_left_d = length;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (rd_en) begin
          rd_left_d = rd_left_q - LEN_ONE;
          // The address stays on the final read once the burst is fully issued.
          if (rd_left_q != LEN_ONE) begin
            addr_d = addr_q + 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && (xf_left_q == LEN_ONE)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    inflight_d = rd_en;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      last_d   = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      xf_left_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      xf_left_q  <= xf_left_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && (count_q == 2'd2) && !pop));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q != 2'd3);

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a behavioural synchronous RAM holding RAM[i] = i*3.
module tb_mem_burst_reader;

  localparam int DW = 16;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  mem_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int occ   = 0;
  int occ_max = 0;
  int iss_addr[$];
  int iss_cyc[$];
  int xf_dat[$];
  int xf_cyc[$];
  int done_cyc[$];
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      if (mem_rd_en) begin
        iss_addr.push_back(int'(mem_addr));
        iss_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        xf_dat.push_back(int'(out_data));
        xf_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      occ = occ + (mem_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (occ > occ_max) occ_max = occ;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iss_addr.delete();
    iss_cyc.delete();
    xf_dat.delete();
    xf_cyc.delete();
    done_cyc.delete();
    occ_max = 0;
  endtask

  task automatic launch(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    step();
    c0    = cyc;
    start = 1'b0;
  endtask

  // mode 1 drives out_ready with the repeating 1,0,0,1 pattern.
  task automatic wait_done(input int maxc, input int mode);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < maxc) begin
      if (mode == 1) out_ready = pat[(n + 1) % 4];
      step();
      n++;
    end
    chk("done_timeout", 32'(done_cyc.size() > 0), 1);
    out_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_iss;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 3);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    step();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_rden",  32'(mem_rd_en), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    rst_n = 1'b1;
    step();

    // basic burst
    clr(); out_ready = 1'b1;
    launch(5, 4);
    wait_done(40, 0);
    chk("bas_niss", iss_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bas_addr", qat(iss_addr, i), 5 + i);
      chk("bas_icyc", qat(iss_cyc, i), c0 + i);
      chk("bas_data", qat(xf_dat, i), 15 + 3 * i);
      chk("bas_xcyc", qat(xf_cyc, i), c0 + 2 + i);
    end
    chk("bas_nxf",   xf_dat.size(), 4);
    chk("bas_ndone", done_cyc.size(), 1);
    chk("bas_dcyc",  qat(done_cyc, 0), c0 + 6);
    chk("bas_idle",  32'(busy), 0);

    // backpressure
    clr(); out_ready = 1'b1;
    launch(0, 6);
    wait_done(80, 1);
    chk("bp_nxf", xf_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_data", qat(xf_dat, i), 3 * i);
    chk("bp_occ_le2", 32'(occ_max <= 2), 1);
    chk("bp_occ_max", occ_max, 2);
    chk("bp_ndone", done_cyc.size(), 1);

    // address wrap
    clr(); out_ready = 1'b1;
    launch(16382, 4);
    wait_done(40, 0);
    chk("wr_a0", qat(iss_addr, 0), 16382);
    chk("wr_a1", qat(iss_addr, 1), 16383);
    chk("wr_a2", qat(iss_addr, 2), 0);
    chk("wr_a3", qat(iss_addr, 3), 1);
    chk("wr_d0", qat(xf_dat, 0), 49146);
    chk("wr_d2", qat(xf_dat, 2), 0);

    // zero length
    clr();
    launch(7, 0);
    chk("zl_done", 32'(done), 1);
    chk("zl_busy", 32'(busy), 1);
    chk("zl_rden", 32'(mem_rd_en), 0);
    step();
    chk("zl_done_off", 32'(done), 0);
    chk("zl_busy_off", 32'(busy), 0);
    step();
    chk("zl_niss",  iss_addr.size(), 0);
    chk("zl_ndone", done_cyc.size(), 1);

    // start re-asserted mid-burst
    clr(); out_ready = 1'b1;
    launch(10, 4);
    start = 1'b1; base_addr = AW'(100); length = (AW+1)'(7);
    step();
    step();
    start = 1'b0;
    wait_done(40, 0);
    chk("ig_nxf",  xf_dat.size(), 4);
    chk("ig_niss", iss_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk("ig_data", qat(xf_dat, i), 30 + 3 * i);
    chk("ig_ndone", done_cyc.size(), 1);

    // stall at the last word
    clr(); out_ready = 1'b0;
    launch(20, 2);
    repeat (4) step();
    chk("st_valid", 32'(out_valid), 1);
    chk("st_data",  32'(out_data), 60);
    chk("st_rden",  32'(mem_rd_en), 0);
    chk("st_niss",  iss_addr.size(), 2);
    chk("st_nxf0",  xf_dat.size(), 0);
    out_ready = 1'b1;
    wait_done(20, 0);
    chk("st_d0",   qat(xf_dat, 0), 60);
    chk("st_d1",   qat(xf_dat, 1), 63);
    chk("st_c1",   qat(xf_cyc, 1), c0 + 5);
    chk("st_cdn",  qat(done_cyc, 0), qat(xf_cyc, 1) + 1);

    // whole-RAM burst
    clr(); out_ready = 1'b1;
    launch(3, 1 << AW);
    wait_done(17000, 0);
    chk("full_nxf",   xf_dat.size(), 1 << AW);
    chk("full_first", qat(xf_dat, 0), 9);
    chk("full_last",  qat(xf_dat, (1 << AW) - 1), 6);
    chk("full_alast", qat(iss_addr, (1 << AW) - 1), 2);
    chk("full_dcyc",  qat(done_cyc, 0), c0 + (1 << AW) + 2);

    // reset mid-burst after 3 of 8 words
    clr(); out_ready = 1'b1;
    launch(0, 8);
    n = 0;
    while (xf_dat.size() < 3 && n < 20) begin
      step();
      n++;
    end
    chk("rm_pre_busy", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rm_busy",  32'(busy), 0);
    chk("rm_valid", 32'(out_valid), 0);
    chk("rm_rden",  32'(mem_rd_en), 0);
    chk("rm_done",  32'(done), 0);
    n_iss = iss_addr.size();
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rm_nxf",   xf_dat.size(), 3);
    chk("rm_niss",  iss_addr.size(), n_iss);
    chk("rm_idle",  32'(busy), 0);
    chk("rm_ndone", done_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
